// File: rtl/avalon_uart_tx_slave_if.sv
// Avalon-MM bus bundle between the core's peripheral master and the UART TX console slave.
//   av_address     word offset (0 = DATA, 1 = CONTROL, 2..3 reserved)
//   av_read_n      active-low read strobe
//   av_write_n     active-low write strobe
//   av_writedata   write data
//   av_readdata    read data from the slave
//   av_waitrequest slave stall indication
interface avalon_uart_tx_slave_if;
   logic [1:0]  av_address;
   logic        av_read_n;
   logic        av_write_n;
   logic [31:0] av_writedata;
   logic [31:0] av_readdata;
   logic        av_waitrequest;

   modport master (
      output av_address, av_read_n, av_write_n, av_writedata,
      input  av_readdata, av_waitrequest
   );

   modport slave (
      input  av_address, av_read_n, av_write_n, av_writedata,
      output av_readdata, av_waitrequest
   );
endinterface

// File: rtl/avalon_uart_tx_slave.sv
// Avalon-MM console slave: queues written bytes in a TX FIFO and sends them 8N1 on tx.
//   clk    system clock
//   reset  synchronous, active-high reset
//   av     Avalon-MM slave bus (DATA at offset 0, CONTROL at offset 1)
//   tx     UART serial output, idle high
//   irq    TX-drained interrupt (IE & FIFO empty & transmitter idle), registered
module avalon_uart_tx_slave #(
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter int unsigned FIFO_DEPTH   = 16,
   parameter int unsigned LEVEL_W      = 5
) (
   input  logic                    clk,
   input  logic                    reset,
   avalon_uart_tx_slave_if.slave   av,
   output logic                    tx,
   output logic                    irq
);

   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = 16;
   localparam logic [CNT_W-1:0] BAUD_RELOAD = CNT_W'(CLKS_PER_BIT - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   logic [7:0]         fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [LEVEL_W-1:0] level;

   logic [1:0]         state;
   logic [1:0]         state_nxt;
   logic [CNT_W-1:0]   baud_cnt;
   logic [CNT_W-1:0]   baud_nxt;
   logic [2:0]         bit_idx;
   logic [2:0]         idx_nxt;
   logic [7:0]         shift;
   logic [7:0]         shift_nxt;
   logic               tx_nxt;

   logic               ie;
   logic               rd_done;
   logic [31:0]        readdata_q;
   logic [31:0]        rd_value;

   logic               wr_access;
   logic               rd_access;
   logic               is_data;
   logic               is_ctrl;
   logic               full;
   logic               empty;
   logic               push;
   logic               pop;
   logic               flush;
   logic               ctrl_wr;
   logic               can_pop;
   logic               busy;
   logic               drained;
   logic               unused_wdata;

   // Bus decode; a write wins over a simultaneous read
   assign wr_access = ~av.av_write_n;
   assign rd_access = ~av.av_read_n & av.av_write_n;
   assign is_data   = (av.av_address == 2'd0);
   assign is_ctrl   = (av.av_address == 2'd1);
   assign full      = (level == LEVEL_W'(FIFO_DEPTH));
   assign empty     = (level == '0);
   assign push      = wr_access & is_data & ~full;
   assign ctrl_wr   = wr_access & is_ctrl;
   assign flush     = ctrl_wr & av.av_writedata[1];
   assign can_pop   = ~empty & ~flush;
   assign busy      = (state != ST_IDLE);
   assign drained   = empty & ~busy;
   assign unused_wdata = ^av.av_writedata[31:8];

   assign av.av_readdata = readdata_q;

   // Writes stall only on a full FIFO; reads take exactly one wait state
   always_comb begin
      av.av_waitrequest = 1'b0;
      if (wr_access) begin
         av.av_waitrequest = is_data & full;
      end else if (rd_access) begin
         av.av_waitrequest = ~rd_done;
      end
   end

   // Register file read mux
   always_comb begin
      rd_value = '0;
      case (av.av_address)
         2'd0: rd_value[31:16] = 16'(FIFO_DEPTH) - 16'(level);
         2'd1: begin
            rd_value[0]              = ie;
            rd_value[8]              = drained;
            rd_value[9]              = busy;
            rd_value[10]             = full;
            rd_value[11]             = empty;
            rd_value[16 +: LEVEL_W]  = level;
         end
         default: rd_value = '0;
      endcase
   end

   // TX next-state logic; tx is registered alongside the state it belongs to
   always_comb begin
      state_nxt = state;
      baud_nxt  = baud_cnt;
      idx_nxt   = bit_idx;
      shift_nxt = shift;
      tx_nxt    = tx;
      pop       = 1'b0;
      case (state)
         ST_IDLE: begin
            tx_nxt = 1'b1;
            if (can_pop) begin
               pop       = 1'b1;
               shift_nxt = fifo_mem[rd_ptr];
               baud_nxt  = BAUD_RELOAD;
               state_nxt = ST_START;
               tx_nxt    = 1'b0;
            end
         end
         ST_START: begin
            if (baud_cnt == '0) begin
               baud_nxt  = BAUD_RELOAD;
               idx_nxt   = 3'd0;
               state_nxt = ST_DATA;
               tx_nxt    = shift[0];
            end else begin
               baud_nxt = baud_cnt - CNT_W'(1);
            end
         end
         ST_DATA: begin
            if (baud_cnt == '0) begin
               baud_nxt = BAUD_RELOAD;
               if (bit_idx == 3'd7) begin
                  state_nxt = ST_STOP;
                  tx_nxt    = 1'b1;
               end else begin
                  idx_nxt   = bit_idx + 3'd1;
                  shift_nxt = {1'b0, shift[7:1]};
                  tx_nxt    = shift[1];
               end
            end else begin
               baud_nxt = baud_cnt - CNT_W'(1);
            end
         end
         ST_STOP: begin
            if (baud_cnt == '0) begin
               // Chain straight into the next start bit when more data waits
               if (can_pop) begin
                  pop       = 1'b1;
                  shift_nxt = fifo_mem[rd_ptr];
                  baud_nxt  = BAUD_RELOAD;
                  state_nxt = ST_START;
                  tx_nxt    = 1'b0;
               end else begin
                  state_nxt = ST_IDLE;
                  tx_nxt    = 1'b1;
               end
            end else begin
               baud_nxt = baud_cnt - CNT_W'(1);
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            tx_nxt    = 1'b1;
         end
      endcase
   end

   // FIFO storage (no reset needed; level gates every read)
   always_ff @(posedge clk) begin
      if (push && !reset) begin
         fifo_mem[wr_ptr] <= av.av_writedata[7:0];
      end
   end

   // State, FIFO bookkeeping, control and bus registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         baud_cnt   <= '0;
         bit_idx    <= '0;
         shift      <= '0;
         tx         <= 1'b1;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         level      <= '0;
         ie         <= 1'b0;
         irq        <= 1'b0;
         rd_done    <= 1'b0;
         readdata_q <= '0;
      end else begin
         state    <= state_nxt;
         baud_cnt <= baud_nxt;
         bit_idx  <= idx_nxt;
         shift    <= shift_nxt;
         tx       <= tx_nxt;

         // Flush drops queued bytes only; the frame in the shifter keeps going
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
               2'b10:   level <= level + LEVEL_W'(1);
               2'b01:   level <= level - LEVEL_W'(1);
               default: level <= level;
            endcase
         end

         if (ctrl_wr) ie <= av.av_writedata[0];
         irq <= ie & drained;

         rd_done <= rd_access & ~rd_done;
         if (rd_access && !rd_done) readdata_q <= rd_value;
      end
   end

endmodule
